// File: rtl/serial_word_transmitter_if.sv
// Parallel word handshake between a producer and the serial transmitter.
// Latency: none, this file only declares wires.
// Backpressure: the producer holds data_valid and data_in until data_ready is seen high.
interface serial_word_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    // Producer side: offers words and watches data_ready.
    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    // Transmitter side: consumes words when it is idle.
    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_word_transmitter.sv
// Framed serial transmitter: start 0, WIDTH data bits LSB-first, stop 1, each bit held CLKS_PER_BIT cycles.
// Latency: start bit appears the cycle after acceptance; frame lasts (WIDTH+2)*CLKS_PER_BIT cycles, done follows.
// Backpressure: data_ready is high only in IDLE (including the done cycle); nothing is queued while busy.
module serial_word_transmitter #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                        clock,
    input  logic                        clear,
    serial_word_transmitter_if.slave    link,
    output logic                        serial_out,
    output logic                        busy,
    output logic                        done
);

    // Counter widths never drop below one bit so CLKS_PER_BIT=1 or WIDTH=1 still elaborate.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_nxt;
    logic [IW-1:0]    bit_idx;
    logic [IW-1:0]    bit_idx_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             done_q;
    logic             done_nxt;

    logic             bit_end;

    // A bit period ends on the last count of the per-bit counter.
    assign bit_end = (bit_cnt == CNT_LAST);

    // State, counters, shift register and done flag; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic: walk START -> DATA x WIDTH -> STOP, one bit period each.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (link.data_valid) begin
                    shreg_nxt   = link.data_in;
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = shreg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IW'(1);
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line level decoded purely from registered state: idle/stop high, start low, data from shift LSB.
    always_comb begin
        serial_out = 1'b1;
        case (state)
            START:   serial_out = 1'b0;
            DATA:    serial_out = shreg[0];
            default: serial_out = 1'b1;
        endcase
    end

    assign link.data_ready = (state == IDLE);
    assign busy            = (state != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: directed scenarios plus randomized frames against a frame-level model.
// Latency: sampled 1 time unit after each rising edge.
// Backpressure: producer holds data_valid until data_ready, except where rejection is being exercised.
module tb_serial_word_transmitter;

    localparam int WA  = 8;
    localparam int CA  = 4;
    localparam int FLA = (WA + 2) * CA;
    localparam int WB  = 5;
    localparam int CB  = 1;
    localparam int FLB = (WB + 2) * CB;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clear_a;
    logic clear_b;
    logic so_a, busy_a, done_a;
    logic so_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    serial_word_transmitter_if #(.WIDTH(WA)) link_a ();
    serial_word_transmitter_if #(.WIDTH(WB)) link_b ();

    serial_word_transmitter #(.WIDTH(WA), .CLKS_PER_BIT(CA)) dut_a (
        .clock      (clock),
        .clear      (clear_a),
        .link       (link_a.slave),
        .serial_out (so_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    serial_word_transmitter #(.WIDTH(WB), .CLKS_PER_BIT(CB)) dut_b (
        .clock      (clock),
        .clear      (clear_b),
        .link       (link_b.slave),
        .serial_out (so_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // Frame model: off is the cycle count after the accepting edge (off=1 is the first start-bit cycle).
    function automatic logic model_line(input logic [31:0] word, input int w, input int cpb, input int off);
        int slot;
        if (off < 1 || off > (w + 2) * cpb) return 1'b1;
        slot = (off - 1) / cpb;
        if (slot == 0) return 1'b0;
        if (slot == w + 1) return 1'b1;
        return word[slot - 1];
    endfunction

    function automatic logic model_busy(input int w, input int cpb, input int off);
        return (off >= 1) && (off <= (w + 2) * cpb);
    endfunction

    function automatic logic model_done(input int w, input int cpb, input int off);
        return off == (w + 2) * cpb + 1;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        clear_a = 1'b1;
        clear_b = 1'b1;
        link_a.data_valid = 1'b1;
        link_a.data_in    = 8'($urandom);
        link_b.data_valid = 1'b1;
        link_b.data_in    = 5'($urandom);
        repeat (2) begin
            tick();
            checks++;
            if ({so_a, link_a.data_ready, busy_a, done_a} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_a so/rdy/busy/done got %b want 1100", {so_a, link_a.data_ready, busy_a, done_a});
            end
            checks++;
            if ({so_b, link_b.data_ready, busy_b, done_b} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_b so/rdy/busy/done got %b want 1100", {so_b, link_b.data_ready, busy_b, done_b});
            end
        end
        link_a.data_valid = 1'b0;
        link_b.data_valid = 1'b0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        repeat (3) tick();
        checks++;
        if ({so_a, busy_a, so_b, busy_b} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_no_frame so_a/busy_a/so_b/busy_b got %b want 1010", {so_a, busy_a, so_b, busy_b});
        end
    endtask

    task automatic test_single_frame;
        logic [7:0] w;
        w = 8'hA5;
        link_a.data_in    = w;
        link_a.data_valid = 1'b1;
        tick();
        link_a.data_valid = 1'b0;
        for (int off = 1; off <= FLA + 1; off++) begin
            checks++;
            if ({so_a, busy_a, done_a, link_a.data_ready} !==
                {model_line(32'(w), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off), ~model_busy(WA, CA, off)}) begin
                errors++;
                $display("FAIL single_frame off=%0d so/busy/done/rdy got %b%b%b%b want %b%b%b%b", off,
                         so_a, busy_a, done_a, link_a.data_ready, model_line(32'(w), WA, CA, off),
                         model_busy(WA, CA, off), model_done(WA, CA, off), ~model_busy(WA, CA, off));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'h3C;
        w2 = 8'h00;
        link_a.data_in    = w1;
        link_a.data_valid = 1'b1;
        tick();
        for (int off = 1; off <= FLA + 1; off++) begin
            checks++;
            if ({so_a, busy_a, done_a} !== {model_line(32'(w1), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off)}) begin
                errors++;
                $display("FAIL b2b_first off=%0d so/busy/done got %b%b%b want %b%b%b", off, so_a, busy_a, done_a,
                         model_line(32'(w1), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off));
            end
            if (off == FLA + 1) link_a.data_in = w2;
            tick();
        end
        link_a.data_valid = 1'b0;
        for (int off = 1; off <= FLA + 1; off++) begin
            checks++;
            if ({so_a, busy_a, done_a} !== {model_line(32'(w2), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off)}) begin
                errors++;
                $display("FAIL b2b_second off=%0d so/busy/done got %b%b%b want %b%b%b", off, so_a, busy_a, done_a,
                         model_line(32'(w2), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off));
            end
            tick();
        end
    endtask

    task automatic test_busy_reject;
        logic [7:0] w;
        w = 8'($urandom);
        link_a.data_in    = w;
        link_a.data_valid = 1'b1;
        tick();
        link_a.data_valid = 1'b0;
        for (int off = 1; off <= FLA + 1; off++) begin
            checks++;
            if ({so_a, busy_a, done_a, link_a.data_ready} !==
                {model_line(32'(w), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off), ~model_busy(WA, CA, off)}) begin
                errors++;
                $display("FAIL busy_reject off=%0d so/busy/done/rdy got %b%b%b%b want %b%b%b%b", off,
                         so_a, busy_a, done_a, link_a.data_ready, model_line(32'(w), WA, CA, off),
                         model_busy(WA, CA, off), model_done(WA, CA, off), ~model_busy(WA, CA, off));
            end
            link_a.data_valid = (off == 10);
            if (off == 10) link_a.data_in = 8'hFF;
            tick();
        end
        repeat (5) begin
            checks++;
            if ({so_a, busy_a, done_a} !== 3'b100) begin
                errors++;
                $display("FAIL busy_reject_queued so/busy/done got %b want 100", {so_a, busy_a, done_a});
            end
            tick();
        end
    endtask

    task automatic test_abort;
        logic [7:0] w;
        w = 8'h81;
        link_a.data_in    = w;
        link_a.data_valid = 1'b1;
        tick();
        link_a.data_valid = 1'b0;
        for (int off = 1; off <= 18; off++) begin
            checks++;
            if ({so_a, busy_a} !== {model_line(32'(w), WA, CA, off), model_busy(WA, CA, off)}) begin
                errors++;
                $display("FAIL abort_pre off=%0d so/busy got %b%b want %b%b", off, so_a, busy_a,
                         model_line(32'(w), WA, CA, off), model_busy(WA, CA, off));
            end
            if (off == 18) clear_a = 1'b1;
            tick();
        end
        clear_a = 1'b0;
        checks++;
        if ({so_a, busy_a, done_a, link_a.data_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL abort_after so/busy/done/rdy got %b want 1001", {so_a, busy_a, done_a, link_a.data_ready});
        end
        repeat (30) begin
            tick();
            checks++;
            if ({so_a, busy_a, done_a} !== 3'b100) begin
                errors++;
                $display("FAIL abort_idle so/busy/done got %b want 100", {so_a, busy_a, done_a});
            end
        end
        w = 8'h55;
        link_a.data_in    = w;
        link_a.data_valid = 1'b1;
        tick();
        link_a.data_valid = 1'b0;
        for (int off = 1; off <= FLA + 1; off++) begin
            checks++;
            if ({so_a, busy_a, done_a} !== {model_line(32'(w), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off)}) begin
                errors++;
                $display("FAIL abort_next off=%0d so/busy/done got %b%b%b want %b%b%b", off, so_a, busy_a, done_a,
                         model_line(32'(w), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off));
            end
            tick();
        end
    endtask

    task automatic test_random;
        logic [7:0] w;
        int gap;
        for (int n = 0; n < 16; n++) begin
            w   = 8'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            link_a.data_in    = w;
            link_a.data_valid = 1'b1;
            tick();
            for (int off = 1; off <= FLA + 1; off++) begin
                checks++;
                if ({so_a, busy_a, done_a} !== {model_line(32'(w), WA, CA, off), model_busy(WA, CA, off), model_done(WA, CA, off)}) begin
                    errors++;
                    $display("FAIL random n=%0d word=%h off=%0d so/busy/done got %b%b%b want %b%b%b", n, w, off,
                             so_a, busy_a, done_a, model_line(32'(w), WA, CA, off),
                             model_busy(WA, CA, off), model_done(WA, CA, off));
                end
                if (off <= FLA) begin
                    link_a.data_valid = 1'($urandom);
                    link_a.data_in    = 8'($urandom);
                end else begin
                    link_a.data_valid = 1'b0;
                end
                tick();
            end
        end
    endtask

    task automatic test_sweep;
        logic [4:0] w;
        w = 5'b10011;
        link_b.data_in    = w;
        link_b.data_valid = 1'b1;
        tick();
        link_b.data_valid = 1'b0;
        for (int off = 1; off <= FLB + 1; off++) begin
            checks++;
            if ({so_b, busy_b, done_b} !== {model_line(32'(w), WB, CB, off), model_busy(WB, CB, off), model_done(WB, CB, off)}) begin
                errors++;
                $display("FAIL sweep off=%0d so/busy/done got %b%b%b want %b%b%b", off, so_b, busy_b, done_b,
                         model_line(32'(w), WB, CB, off), model_busy(WB, CB, off), model_done(WB, CB, off));
            end
            tick();
        end
    endtask

    initial begin
        clear_a = 1'b1;
        clear_b = 1'b1;
        link_a.data_valid = 1'b0;
        link_a.data_in    = '0;
        link_b.data_valid = 1'b0;
        link_b.data_in    = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_reject();
        test_abort();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake. It shifts the word out on a single line as a framed sequence: start bit 0, data LSB-first, stop bit 1. Each bit is held for CLKS_PER_BIT clock cycles. It is the driving end of the serial link whose receiving end is a chain of one-bit registers capturing `serial_out`.

Parameters:
WIDTH, 8, data word width in bits (>= 1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>= 1)

Ports:
clock  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous reset, active-high
data_in  input  WIDTH  word to transmit, sampled only on acceptance
data_valid  input  1  producer has a word on data_in
data_ready  output  1  transmitter can accept a word this cycle
serial_out  output  1  serial line, idles high
busy  output  1  frame in progress (START, DATA or STOP)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (clear=1 at a rising edge), next-cycle values:
  - state = IDLE, serial_out=1, busy=0, done=0, data_ready=1.
  - Bit counter and bit index = 0; shift register contents don't-care.
- clear has priority over every other input, including data_valid in the same cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: serial_out=1, data_ready=1, busy=0.
    - data_valid=1 at an edge: load data_in into the shift register, clear the bit counter, go to START.
  - START: serial_out=0, data_ready=0, busy=1.
    - Held CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial_out = shift register bit 0.
    - Every CLKS_PER_BIT cycles: shift right by one and increment the bit index.
    - After WIDTH bits, go to STOP.
  - STOP: serial_out=1, held CLKS_PER_BIT cycles, then go to IDLE and assert done.
- done timing:
  - Asserted for exactly the first cycle back in IDLE.
  - data_ready is also 1 in that cycle, so a word offered then is accepted.
- Timing, with acceptance at edge k:
  - Start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
  - Data bit i starts after edge k+(i+1)*CLKS_PER_BIT.
  - Stop bit starts after edge k+(WIDTH+1)*CLKS_PER_BIT.
  - done is high in the cycle after edge k+(WIDTH+2)*CLKS_PER_BIT.
  - Frame length is (WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back frames: the minimum gap between stop bit and next start bit is one idle-high cycle (the done cycle).
- data_in changes after acceptance have no effect on the frame in flight.
- data_valid while busy is ignored (data_ready=0) and no word is queued. The producer must hold data_valid until it sees data_ready.
- CLKS_PER_BIT=1: each bit lasts one cycle and the bit counter is degenerate but correct.
- Counter widths:
  - Bit counter: $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Bit index: $clog2(WIDTH), minimum 1 bit.
  - Neither counter wraps within a frame.
- clear mid-frame: the frame is aborted and the word discarded. Next cycle: IDLE, serial_out=1, no done pulse.

Test Plan:
- Reset: clear=1 for 2 cycles with data_valid=1 -> serial_out=1, data_ready=1, busy=0, done=0, no frame starts.
- Single frame (WIDTH=8, CLKS_PER_BIT=4): data_in=8'hA5, valid for 1 cycle at edge k.
  - serial_out per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high cycles k+1..k+40; done high only in cycle k+41.
- Back-to-back: hold data_valid with 8'h3C, then 8'h00 offered in the done cycle.
  - Second start bit begins exactly 1 cycle after the first stop bit ends.
  - Second frame data bits are all 0.
- Busy rejection: pulse data_valid with 8'hFF mid-frame -> data_ready=0, the frame in flight is unchanged, 8'hFF is never transmitted.
- Abort: clear=1 at the DATA bit-3 slot of 8'h81 -> next cycle serial_out=1, busy=0, no done pulse; a following 8'h55 frame is correct.
- Param sweep CLKS_PER_BIT=1, WIDTH=5: send 5'b10011 -> serial_out 0,1,1,0,0,1,1 on consecutive cycles; done at cycle k+8.
